ml_writeback_arbiter: RTL



---
 rtl/ml_writeback_arbiter.sv | 154 +++++++++++++++
 1 files changed

// File: rtl/ml_writeback_arbiter.sv
// Merges ALU (fixed priority) and mult/div results onto the single register-file write port,
// buffering losing mult/div results in a small FIFO. Optional counters: `define MLWB_PERF_CNT_EN.
module ml_writeback_arbiter #(
    parameter int WD_SIZE    = 32,
    parameter int REG_SIZE   = 5,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                alu_valid_i,
    input  logic [REG_SIZE-1:0] alu_rd_i,
    input  logic [WD_SIZE-1:0]  alu_data_i,
    input  logic                ml_valid_i,
    input  logic [REG_SIZE-1:0] ml_rd_i,
    input  logic [WD_SIZE-1:0]  ml_data_i,
    output logic                ml_stall_o,
    input  logic [REG_SIZE-1:0] rs1_i,
    input  logic [REG_SIZE-1:0] rs2_i,
    output logic                pending_hit_o,
    output logic                rf_we_o,
    output logic [REG_SIZE-1:0] rf_rd_o,
    output logic [WD_SIZE-1:0]  rf_data_o,
    output logic                overflow_o
`ifdef MLWB_PERF_CNT_EN
    ,
    output logic [31:0]         perf_alu_wr_o,
    output logic [31:0]         perf_ml_wr_o,
    output logic [31:0]         perf_stall_o,
    output logic [31:0]         perf_kill_o
`endif
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

    logic [REG_SIZE-1:0] ent_rd   [FIFO_DEPTH];
    logic [WD_SIZE-1:0]  ent_data [FIFO_DEPTH];
    logic                ent_live [FIFO_DEPTH];
    logic [PW-1:0]       head, tail;
    logic [CW-1:0]       count;

    logic alu_eff, ml_req, ml_discard, ml_eff;
    logic empty, full, pop, bypass, push_req, push, drop;
    logic [PW-1:0] idx;

    assign alu_eff    = alu_valid_i && (alu_rd_i != '0);
    assign ml_req     = ml_valid_i && (ml_rd_i != '0);
    // The ALU op is younger, so a same-cycle mult/div result to the same rd is already stale.
    assign ml_discard = alu_eff && ml_req && (ml_rd_i == alu_rd_i);
    assign ml_eff     = ml_req && !ml_discard;

    assign empty      = (count == '0);
    assign full       = (count == FULL_CNT);
    assign pop        = !alu_eff && !empty;
    assign bypass     = !alu_eff && empty && ml_eff;
    assign push_req   = ml_eff && !bypass;
    assign push       = push_req && (!full || pop);
    assign drop       = push_req && full && !pop;
    assign ml_stall_o = full;

    always_comb begin
        pending_hit_o = 1'b0;
        idx           = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && ent_live[idx] && (ent_rd[idx] != '0) &&
                ((ent_rd[idx] == rs1_i) || (ent_rd[idx] == rs2_i)))
                pending_hit_o = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rf_we_o    <= 1'b0;
            rf_rd_o    <= '0;
            rf_data_o  <= '0;
            overflow_o <= 1'b0;
            head       <= '0;
            tail       <= '0;
            count      <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                ent_rd[i]   <= '0;
                ent_data[i] <= '0;
                ent_live[i] <= 1'b0;
            end
        end else begin
            rf_we_o <= 1'b0;
            if (alu_eff) begin
                rf_we_o   <= 1'b1;
                rf_rd_o   <= alu_rd_i;
                rf_data_o <= alu_data_i;
            end else if (pop) begin
                // A killed head still frees its slot but leaves the write port idle.
                if (ent_live[head]) begin
                    rf_we_o   <= 1'b1;
                    rf_rd_o   <= ent_rd[head];
                    rf_data_o <= ent_data[head];
                end
            end else if (bypass) begin
                rf_we_o   <= 1'b1;
                rf_rd_o   <= ml_rd_i;
                rf_data_o <= ml_data_i;
            end

            if (alu_eff) begin
                for (int i = 0; i < FIFO_DEPTH; i++)
                    if (ent_rd[i] == alu_rd_i) ent_live[i] <= 1'b0;
            end
            if (push) begin
                ent_rd[tail]   <= ml_rd_i;
                ent_data[tail] <= ml_data_i;
                ent_live[tail] <= 1'b1;
                tail           <= tail + 1'b1;
            end
            if (pop) head <= head + 1'b1;

            if (push && !pop)      count <= count + 1'b1;
            else if (pop && !push) count <= count - 1'b1;

            if (drop) overflow_o <= 1'b1;
        end
    end

`ifdef MLWB_PERF_CNT_EN
    logic kill_any;
    logic [PW-1:0] kidx;

    always_comb begin
        kill_any = 1'b0;
        kidx     = '0;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            kidx = head + PW'(i);
            if (alu_eff && (CW'(i) < count) && ent_live[kidx] && (ent_rd[kidx] == alu_rd_i))
                kill_any = 1'b1;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            perf_alu_wr_o <= '0;
            perf_ml_wr_o  <= '0;
            perf_stall_o  <= '0;
            perf_kill_o   <= '0;
        end else begin
            if (alu_eff) perf_alu_wr_o <= perf_alu_wr_o + 32'd1;
            if (bypass || (pop && ent_live[head])) perf_ml_wr_o <= perf_ml_wr_o + 32'd1;
            if (ml_stall_o) perf_stall_o <= perf_stall_o + 32'd1;
            if (kill_any || ml_discard) perf_kill_o <= perf_kill_o + 32'd1;
        end
    end
`endif

endmodule
